mem_burst_arbiter: RTL and testbench
====================================

Name: mem_burst_arbiter

Overview:
- Shared byte-serial RAM port controller for the core, generalising the current icache/dcache/MMIO memory sequencer.
- Serves NUM_PORTS block-transfer channels (icache refill, dcache refill, dcache write-back, ...) with round-robin arbitration, plus one uncached MMIO channel of 1/2/4 bytes at highest priority.
- Block length is parametrised.
- Sits between the cache layer and the RAM/IO bus.

Parameters:
- BLOCK_WIDTH, 4, log2 of bytes per block.
- BLOCK_SIZE, 2**BLOCK_WIDTH, bytes per block (derived).
- NUM_PORTS, 3, number of block channels (1..8).
- TAG_W, 32-BLOCK_WIDTH, block address width (derived).

Ports:
- clkIn  in  1  system clock.
- resetIn  in  1  synchronous, active-low reset.
- clearIn  in  1  branch-mispredict flush.
- memIn  in  8  RAM read data; one-cycle latency after address.
- memAddr  out  32  RAM byte address.
- memOut  out  8  RAM write data.
- readWriteOut  out  1  1 = write, 0 = read.
- blkReqValid  in  NUM_PORTS  per-channel request.
- blkReqWrite  in  NUM_PORTS  per-channel direction, 1 = write.
- blkReqAddr  in  NUM_PORTS*TAG_W  per-channel block address (tag).
- blkReqData  in  NUM_PORTS*BLOCK_SIZE*8  per-channel write block.
- blkGrant  out  NUM_PORTS  one-hot, one-cycle accept pulse.
- blkDone  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- blkRdData  out  BLOCK_SIZE*8  read block; byte i at bits [8i+7:8i].
- ioReqSize  in  2  00 none, 01 byte, 10 half, 11 word.
- ioReqWrite  in  1  1 = write.
- ioReqAddr  in  32  MMIO byte address.
- ioReqData  in  32  write data, little-endian.
- ioGrant  out  1  one-cycle accept pulse.
- ioDone  out  1  one-cycle completion pulse.
- ioRdData  out  32  read data, zero-extended.

Behaviour:
- Reset (resetIn=0 at posedge):
  - state=IDLE.
  - All grant/done outputs 0.
  - memAddr=0, memOut=0, readWriteOut=0.
  - blkRdData and ioRdData = 0.
  - Round-robin pointer = NUM_PORTS-1, so port 0 wins first.
  - Reset mid-transfer aborts immediately with no done pulse.
- States: IDLE, RD (issue/capture), WR (issue), DONE.
- Arbitration, evaluated only in IDLE:
  - An io request (size!=00) wins over any block request.
  - Otherwise the first valid channel searching from pointer+1 mod NUM_PORTS wins.
  - The pointer updates to the granted channel.
- Requesters hold valid/addr/data stable until their grant pulse and must drop valid the cycle after.
- Inputs are latched at the accept edge.
- Transfer length N: BLOCK_SIZE for block requests; 1/2/4 for io.
- Addresses:
  - Block: {tag, i[BLOCK_WIDTH-1:0]}.
  - io: ioReqAddr+i, full 32-bit add, so crossing is allowed.
- Read timing (G = grant cycle):
  - Byte i address driven during cycle G+i, i=0..N-1.
  - memIn sampled during G+i+1.
  - DONE, done pulse and valid read data in cycle G+N+1.
  - Next grant no earlier than G+N+2.
- Write timing:
  - Byte i on memAddr/memOut with readWriteOut=1 during cycle G+i.
  - Done pulse in cycle G+N.
  - readWriteOut=0 in every cycle not carrying a write byte.
- Between transfers memAddr=0 and readWriteOut=0.
- Read data:
  - blkRdData/ioRdData hold their value until the next read of the same class completes.
  - Unwritten upper io bytes are 0.
- clearIn:
  - In IDLE, an io read is not accepted that cycle; an io write or block request may be.
  - If clearIn is seen at any cycle during an io read, the bus sequence completes but ioDone is suppressed.
  - Block transfers and io writes are never affected.
- Simultaneous requests on all channels are granted in rotation: 0,1,2,0,...
- A channel that re-asserts valid immediately after done competes normally.

Test Plan:
- Reset, then blkReqValid=001 read, tag=0x0000123 (BLOCK_WIDTH=4), RAM byte k=k+0x10 -> blkGrant=001 at G; memAddr 0x1230..0x123F in G..G+15; blkDone=001 at G+17; blkRdData byte0=0x10, byte15=0x1F.
- Port 1 write, data bytes 0xA0..0xAF, tag 0x0000456 -> readWriteOut=1 for exactly 16 cycles at 0x4560..0x456F with matching memOut; blkDone=010 at G+16; readWriteOut=0 afterwards.
- All three channels plus io word read at 0x00030000 requested together -> io granted first, then ports 0,1,2 in order; no overlapping bus cycles.
- io half write 0xBEEF at 0x0003FFFF -> memAddr 0x0003FFFF/0x00040000 with memOut 0xEF/0xBE; ioDone at G+2.
- io byte read with clearIn pulsed at G+1 -> one address cycle issued, no ioDone; a following io read without clearIn returns a zero-extended byte.
- resetIn=0 asserted at G+5 of a block read -> all outputs at reset values next cycle, no blkDone; a fresh request after release is granted to port 0.

Source files
------------

// File: rtl/mem_burst_arbiter.sv
// Byte-serial RAM port sequencer shared by the block channels (cache refill /
// write-back) and one uncached MMIO channel. MMIO has absolute priority; block
// channels are served round-robin. All bus outputs are registered.
module mem_burst_arbiter #(
    parameter int BLOCK_WIDTH = 4,
    parameter int NUM_PORTS = 3,
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH,
    localparam int TAG_W = 32 - BLOCK_WIDTH
) (
    input  logic                            clkIn,
    input  logic                            resetIn,
    input  logic                            clearIn,
    input  logic [7:0]                      memIn,
    output logic [31:0]                     memAddr,
    output logic [7:0]                      memOut,
    output logic                            readWriteOut,
    input  logic [NUM_PORTS-1:0]            blkReqValid,
    input  logic [NUM_PORTS-1:0]            blkReqWrite,
    input  logic [NUM_PORTS*TAG_W-1:0]      blkReqAddr,
    input  logic [NUM_PORTS*BLOCK_SIZE*8-1:0] blkReqData,
    output logic [NUM_PORTS-1:0]            blkGrant,
    output logic [NUM_PORTS-1:0]            blkDone,
    output logic [BLOCK_SIZE*8-1:0]         blkRdData,
    input  logic [1:0]                      ioReqSize,
    input  logic                            ioReqWrite,
    input  logic [31:0]                     ioReqAddr,
    input  logic [31:0]                     ioReqData,
    output logic                            ioGrant,
    output logic                            ioDone,
    output logic [31:0]                     ioRdData
);

    localparam int BLK_BITS  = BLOCK_SIZE * 8;
    // The staging buffers also carry MMIO words, so they are never narrower than 4 bytes.
    localparam int BUF_BYTES = (BLOCK_SIZE > 4) ? BLOCK_SIZE : 4;
    localparam int BUF_W     = BUF_BYTES * 8;
    localparam int CNT_W     = $clog2(BUF_BYTES) + 1;
    localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic [31:0]      base;
    logic             isIo;
    logic             ioKill;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] curPort;
    logic [BUF_W-1:0] wrBuf;
    logic [BUF_W-1:0] rdBuf;

    logic [CNT_W-1:0] cntInc;
    logic [7:0]       wrByte;
    logic [BUF_W-1:0] rdNext;
    logic             ioAccept;
    logic             pickValid;
    logic [PTR_W-1:0] pickIdx;

    function automatic logic [CNT_W-1:0] ioLen(input logic [1:0] size);
        case (size)
            2'b01:   return CNT_W'(1);
            2'b10:   return CNT_W'(2);
            2'b11:   return CNT_W'(4);
            default: return '0;
        endcase
    endfunction

    // Next byte index, the write byte it selects, and the read buffer with the byte arriving now.
    always_comb begin
        cntInc = cnt + CNT_W'(1);
        wrByte = (int'(cntInc) < BUF_BYTES) ? wrBuf[int'(cntInc)*8 +: 8] : 8'h00;
        rdNext = rdBuf;
        if (cnt != '0) begin
            rdNext[(int'(cnt) - 1)*8 +: 8] = memIn;
        end
    end

    // Request selection: MMIO first (reads held off by a flush), else round-robin from ptr+1.
    always_comb begin
        ioAccept  = (ioReqSize != 2'b00) && !(clearIn && !ioReqWrite);
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!pickValid && blkReqValid[(int'(ptr) + k) % NUM_PORTS]) begin
                pickValid = 1'b1;
                pickIdx   = PTR_W'((int'(ptr) + k) % NUM_PORTS);
            end
        end
    end

    // Transfer sequencer: accept in IDLE, stream bytes in RD/WR, one-cycle DONE before re-arbitration.
    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            len          <= '0;
            base         <= '0;
            isIo         <= 1'b0;
            ioKill       <= 1'b0;
            ptr          <= PTR_W'(NUM_PORTS - 1);
            curPort      <= '0;
            wrBuf        <= '0;
            rdBuf        <= '0;
            memAddr      <= '0;
            memOut       <= '0;
            readWriteOut <= 1'b0;
            blkGrant     <= '0;
            blkDone      <= '0;
            blkRdData    <= '0;
            ioGrant      <= 1'b0;
            ioDone       <= 1'b0;
            ioRdData     <= '0;
        end else begin
            blkGrant <= '0;
            blkDone  <= '0;
            ioGrant  <= 1'b0;
            ioDone   <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt    <= '0;
                    ioKill <= 1'b0;
                    rdBuf  <= '0;
                    if (ioAccept) begin
                        isIo         <= 1'b1;
                        len          <= ioLen(ioReqSize);
                        base         <= ioReqAddr;
                        wrBuf        <= BUF_W'(ioReqData);
                        ioGrant      <= 1'b1;
                        memAddr      <= ioReqAddr;
                        memOut       <= ioReqWrite ? ioReqData[7:0] : 8'h00;
                        readWriteOut <= ioReqWrite;
                        state        <= ioReqWrite ? S_WR : S_RD;
                    end else if (pickValid) begin
                        isIo         <= 1'b0;
                        len          <= CNT_W'(BLOCK_SIZE);
                        base         <= {blkReqAddr[int'(pickIdx)*TAG_W +: TAG_W], {BLOCK_WIDTH{1'b0}}};
                        wrBuf        <= BUF_W'(blkReqData[int'(pickIdx)*BLK_BITS +: BLK_BITS]);
                        ptr          <= pickIdx;
                        curPort      <= pickIdx;
                        blkGrant     <= NUM_PORTS'(1) << pickIdx;
                        memAddr      <= {blkReqAddr[int'(pickIdx)*TAG_W +: TAG_W], {BLOCK_WIDTH{1'b0}}};
                        memOut       <= blkReqWrite[pickIdx] ? blkReqData[int'(pickIdx)*BLK_BITS +: 8] : 8'h00;
                        readWriteOut <= blkReqWrite[pickIdx];
                        state        <= blkReqWrite[pickIdx] ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    // Address for byte cnt is on the bus now; memIn carries byte cnt-1.
                    cnt   <= cntInc;
                    rdBuf <= rdNext;
                    if (clearIn) begin
                        ioKill <= 1'b1;
                    end
                    memAddr <= (cntInc < len) ? base + 32'(cntInc) : 32'h0;
                    if (cnt == len) begin
                        state <= S_DONE;
                        if (isIo) begin
                            if (!(ioKill || clearIn)) begin
                                ioDone   <= 1'b1;
                                ioRdData <= rdNext[31:0];
                            end
                        end else begin
                            blkDone   <= NUM_PORTS'(1) << curPort;
                            blkRdData <= rdNext[BLK_BITS-1:0];
                        end
                    end
                end
                S_WR: begin
                    cnt <= cntInc;
                    if (cntInc < len) begin
                        memAddr      <= base + 32'(cntInc);
                        memOut       <= wrByte;
                        readWriteOut <= 1'b1;
                    end else begin
                        memAddr      <= '0;
                        memOut       <= '0;
                        readWriteOut <= 1'b0;
                        state        <= S_DONE;
                        if (isIo) begin
                            ioDone <= 1'b1;
                        end else begin
                            blkDone <= NUM_PORTS'(1) << curPort;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: stimulus pushes expected bus events,
// a negedge monitor pops and compares them with cycle offsets from each grant.
module tb_mem_burst_arbiter;

    localparam int BW = 4;
    localparam int NP = 3;
    localparam int BS = 16;
    localparam int TW = 28;

    localparam int K_GNT = 0;
    localparam int K_RA  = 1;
    localparam int K_WB  = 2;
    localparam int K_BD  = 3;
    localparam int K_ID  = 4;

    logic             clkIn = 1'b0;
    logic             resetIn = 1'b0;
    logic             clearIn = 1'b0;
    logic [7:0]       memIn = 8'h00;
    logic [31:0]      memAddr;
    logic [7:0]       memOut;
    logic             readWriteOut;
    logic [NP-1:0]    blkReqValid = '0;
    logic [NP-1:0]    blkReqWrite = '0;
    logic [NP*TW-1:0] blkReqAddr = '0;
    logic [NP*BS*8-1:0] blkReqData = '0;
    logic [NP-1:0]    blkGrant;
    logic [NP-1:0]    blkDone;
    logic [BS*8-1:0]  blkRdData;
    logic [1:0]       ioReqSize = 2'b00;
    logic             ioReqWrite = 1'b0;
    logic [31:0]      ioReqAddr = '0;
    logic [31:0]      ioReqData = '0;
    logic             ioGrant;
    logic             ioDone;
    logic [31:0]      ioRdData;

    mem_burst_arbiter #(.BLOCK_WIDTH(BW), .NUM_PORTS(NP)) dut (
        .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn), .memIn(memIn),
        .memAddr(memAddr), .memOut(memOut), .readWriteOut(readWriteOut),
        .blkReqValid(blkReqValid), .blkReqWrite(blkReqWrite), .blkReqAddr(blkReqAddr),
        .blkReqData(blkReqData), .blkGrant(blkGrant), .blkDone(blkDone), .blkRdData(blkRdData),
        .ioReqSize(ioReqSize), .ioReqWrite(ioReqWrite), .ioReqAddr(ioReqAddr),
        .ioReqData(ioReqData), .ioGrant(ioGrant), .ioDone(ioDone), .ioRdData(ioRdData)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        int           kind;
        int           off;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [127:0] d;
        bit           chkD;
    } ev_t;

    ev_t          q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           gCyc = 0;
    logic [127:0] expBlkRd = '0;
    logic [31:0]  expIoRd = '0;

    // RAM contents: byte at address a is a[7:0]-0x20 (so 0x1230+k holds 0x10+k).
    function automatic logic [7:0] ramRead(input logic [31:0] a);
        return a[7:0] - 8'h20;
    endfunction

    always @(posedge clkIn) memIn <= ramRead(memAddr);
    always @(posedge clkIn) cyc <= cyc + 1;

    task automatic pushEv(input int kind, input int off, input logic [31:0] a,
                          input logic [31:0] b, input logic [127:0] d, input bit chkD);
        ev_t e;
        e.kind = kind; e.off = off; e.a = a; e.b = b; e.d = d; e.chkD = chkD;
        q.push_back(e);
    endtask

    task automatic expBlkRead(input int port, input logic [TW-1:0] tag, input int nAddr, input bit withDone);
        logic [127:0] d;
        pushEv(K_GNT, 0, 32'h0, 32'(1 << port), '0, 1'b0);
        for (int i = 0; i < nAddr; i++) pushEv(K_RA, i, {tag, 4'(i)}, 32'h0, '0, 1'b0);
        if (withDone) begin
            for (int k = 0; k < BS; k++) d[8*k +: 8] = ramRead({tag, 4'(k)});
            pushEv(K_BD, BS + 1, 32'h0, 32'(1 << port), d, 1'b1);
            expBlkRd = d;
        end
    endtask

    task automatic expBlkWrite(input int port, input logic [TW-1:0] tag, input logic [7:0] b0);
        pushEv(K_GNT, 0, 32'h0, 32'(1 << port), '0, 1'b0);
        for (int i = 0; i < BS; i++) pushEv(K_WB, i, {tag, 4'(i)}, 32'(b0 + 8'(i)), '0, 1'b0);
        pushEv(K_BD, BS, 32'h0, 32'(1 << port), expBlkRd, 1'b1);
    endtask

    task automatic expIoRead(input logic [31:0] addr, input int n, input bit kill);
        logic [31:0] v;
        v = '0;
        pushEv(K_GNT, 0, 32'h1, 32'h0, '0, 1'b0);
        for (int i = 0; i < n; i++) begin
            pushEv(K_RA, i, addr + 32'(i), 32'h0, '0, 1'b0);
            v[8*i +: 8] = ramRead(addr + 32'(i));
        end
        if (!kill) begin
            pushEv(K_ID, n + 1, v, 32'h0, '0, 1'b0);
            expIoRd = v;
        end
    endtask

    task automatic expIoWrite(input logic [31:0] addr, input int n, input logic [31:0] data);
        pushEv(K_GNT, 0, 32'h1, 32'h0, '0, 1'b0);
        for (int i = 0; i < n; i++) pushEv(K_WB, i, addr + 32'(i), 32'(data[8*i +: 8]), '0, 1'b0);
        pushEv(K_ID, n, expIoRd, 32'h0, '0, 1'b0);
    endtask

    task automatic popCheck(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [127:0] d);
        ev_t e;
        bit  ok;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d off=%0d a=%h b=%h required=no event", kind, cyc - gCyc, a, b);
        end else begin
            e = q.pop_front();
            ok = (e.kind == kind) && (kind == K_GNT || e.off == cyc - gCyc) &&
                 (e.a === a) && (e.b === b) && (!e.chkD || e.d === d);
            if (!ok) begin
                failures++;
                $display("FAIL scoreboard got kind=%0d off=%0d a=%h b=%h d=%h required kind=%0d off=%0d a=%h b=%h d=%h",
                         kind, cyc - gCyc, a, b, d, e.kind, e.off, e.a, e.b, e.d);
            end
        end
    endtask

    // Monitor: one grant, one bus byte and one done at most per cycle, in that order.
    always @(negedge clkIn) begin
        if (blkGrant != '0 || ioGrant) begin
            gCyc = cyc;
            popCheck(K_GNT, {31'b0, ioGrant}, 32'(blkGrant), '0);
        end
        if (readWriteOut) popCheck(K_WB, memAddr, {24'b0, memOut}, '0);
        else if (memAddr != 32'h0) popCheck(K_RA, memAddr, 32'h0, '0);
        if (blkDone != '0) popCheck(K_BD, 32'h0, 32'(blkDone), blkRdData);
        if (ioDone) popCheck(K_ID, ioRdData, 32'h0, '0);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clkIn);
        #1;
    endtask

    task automatic waitGrant(input string name);
        for (int c = 0; c < 20; c++) begin
            @(posedge clkIn);
            #1;
            if (blkGrant != '0 || ioGrant) return;
        end
        checks++;
        failures++;
        $display("FAIL %s grant_timeout got none required grant within 20 cycles", name);
    endtask

    task automatic checkZero(input string name);
        checks++;
        if ({memAddr, memOut, readWriteOut} !== '0) begin
            failures++;
            $display("FAIL %s_bus got addr=%h out=%h rw=%b required 0", name, memAddr, memOut, readWriteOut);
        end
        checks++;
        if ({blkGrant, blkDone, ioGrant, ioDone} !== '0) begin
            failures++;
            $display("FAIL %s_hs got bg=%b bd=%b ig=%b id=%b required 0", name, blkGrant, blkDone, ioGrant, ioDone);
        end
        checks++;
        if ({blkRdData, ioRdData} !== '0) begin
            failures++;
            $display("FAIL %s_rd got blk=%h io=%h required 0", name, blkRdData, ioRdData);
        end
    endtask

    task automatic setBlk(input int p, input logic [TW-1:0] tag, input bit wr, input logic [7:0] b0);
        blkReqAddr[p*TW +: TW] = tag;
        blkReqWrite[p] = wr;
        for (int k = 0; k < BS; k++) blkReqData[(p*BS + k)*8 +: 8] = b0 + 8'(k);
    endtask

    task automatic applyReset();
        resetIn = 1'b0;
        idle(2);
        resetIn = 1'b1;
        expBlkRd = '0;
        expIoRd = '0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        checkZero("reset");
        resetIn = 1'b1;
        idle(2);
        checkZero("idle_after_reset");

        // Port 0 block read, tag 0x123
        expBlkRead(0, 28'h0000123, BS, 1'b1);
        setBlk(0, 28'h0000123, 1'b0, 8'h00);
        blkReqValid = 3'b001;
        waitGrant("blk_read");
        blkReqValid = '0;
        idle(25);

        // Port 1 block write, tag 0x456, bytes 0xA0..0xAF; blkRdData must hold
        expBlkWrite(1, 28'h0000456, 8'hA0);
        setBlk(1, 28'h0000456, 1'b1, 8'hA0);
        blkReqValid = 3'b010;
        waitGrant("blk_write");
        blkReqValid = '0;
        idle(25);

        // All channels plus io word read together after a fresh reset
        applyReset();
        expIoRead(32'h0003_0000, 4, 1'b0);
        expBlkRead(0, 28'h0000ABC, BS, 1'b1);
        expBlkWrite(1, 28'h0000DEF, 8'h50);
        expBlkRead(2, 28'h0000777, BS, 1'b1);
        setBlk(0, 28'h0000ABC, 1'b0, 8'h00);
        setBlk(1, 28'h0000DEF, 1'b1, 8'h50);
        setBlk(2, 28'h0000777, 1'b0, 8'h00);
        ioReqSize = 2'b11; ioReqWrite = 1'b0; ioReqAddr = 32'h0003_0000;
        blkReqValid = 3'b111;
        for (int c = 0; c < 300 && (blkReqValid != '0 || ioReqSize != 2'b00); c++) begin
            @(posedge clkIn);
            #1;
            if (ioGrant) ioReqSize = 2'b00;
            blkReqValid = blkReqValid & ~blkGrant;
        end
        if (blkReqValid != '0 || ioReqSize != 2'b00) begin
            checks++;
            failures++;
            $display("FAIL all_ports grant_timeout got pending=%b io=%b required none", blkReqValid, ioReqSize);
            blkReqValid = '0;
            ioReqSize = 2'b00;
        end
        idle(25);

        // io half write across a 64 KiB boundary
        expIoWrite(32'h0003_FFFF, 2, 32'h0000_BEEF);
        ioReqSize = 2'b10; ioReqWrite = 1'b1; ioReqAddr = 32'h0003_FFFF; ioReqData = 32'h0000_BEEF;
        waitGrant("io_write");
        ioReqSize = 2'b00;
        idle(6);

        // io byte read killed by a flush at G+1
        expIoRead(32'h0000_0155, 1, 1'b1);
        ioReqSize = 2'b01; ioReqWrite = 1'b0; ioReqAddr = 32'h0000_0155;
        waitGrant("io_kill");
        ioReqSize = 2'b00;
        @(posedge clkIn); #1;
        clearIn = 1'b1;
        @(posedge clkIn); #1;
        clearIn = 1'b0;
        idle(6);

        // io read held off while clearIn is high, then served normally
        clearIn = 1'b1;
        ioReqSize = 2'b01; ioReqWrite = 1'b0; ioReqAddr = 32'h0000_0166;
        for (int c = 0; c < 3; c++) begin
            @(posedge clkIn); #1;
            checks++;
            if (ioGrant !== 1'b0) begin
                failures++;
                $display("FAIL io_blocked_by_clear got ioGrant=%b required 0", ioGrant);
            end
        end
        expIoRead(32'h0000_0166, 1, 1'b0);
        clearIn = 1'b0;
        waitGrant("io_after_clear");
        ioReqSize = 2'b00;
        idle(6);

        // Reset during a block read at G+5
        expBlkRead(0, 28'h0000321, 6, 1'b0);
        setBlk(0, 28'h0000321, 1'b0, 8'h00);
        blkReqValid = 3'b001;
        waitGrant("abort_read");
        blkReqValid = '0;
        repeat (5) @(posedge clkIn);
        #1;
        resetIn = 1'b0;
        @(posedge clkIn); #1;
        checkZero("reset_abort");
        @(posedge clkIn); #1;
        resetIn = 1'b1;
        expBlkRd = '0;
        expIoRd = '0;
        idle(2);

        // Pointer back at reset value: port 0 beats port 1
        expBlkRead(0, 28'h0000111, BS, 1'b1);
        setBlk(0, 28'h0000111, 1'b0, 8'h00);
        setBlk(1, 28'h0000222, 1'b0, 8'h00);
        blkReqValid = 3'b011;
        waitGrant("rr_after_reset");
        checks++;
        if (blkGrant !== 3'b001) begin
            failures++;
            $display("FAIL rr_after_reset got blkGrant=%b required 001", blkGrant);
        end
        blkReqValid = '0;
        idle(25);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending events required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
